// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock,
// round keys rebuilt backwards from the round-10 key.
module aes_decrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic [127:0] out_key
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] a, x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a     = c[31-8*i -: 8];
            x2    = xt(a);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        unique case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_e         fsm_q;
    logic [127:0]   st_q, rk_q, pt_q, key_q;
    logic [3:0]     rnd_q;
    logic           in_ready_q, out_valid_q;

    logic [31:0]    p0, p1, p2, p3, rot;
    logic [127:0]   rk_d, isb, t_d, mix_d;

    always_comb begin
        p3   = rk_q[31:0] ^ rk_q[63:32];
        p2   = rk_q[63:32] ^ rk_q[95:64];
        p1   = rk_q[95:64] ^ rk_q[127:96];
        // RotWord then SubWord of the recovered last word
        rot  = {sbox(p3[23:16]), sbox(p3[15:8]),
                sbox(p3[7:0]), sbox(p3[31:24])};
        p0   = rk_q[127:96] ^ rot ^ {rcon(rnd_q + 4'd1), 24'h0};
        rk_d = {p0, p1, p2, p3};
        isb  = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isb[127-8*(4*c+r) -: 8] =
                    inv_sbox(st_q[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        t_d   = isb ^ rk_d;
        mix_d = {inv_mix(t_d[127:96]), inv_mix(t_d[95:64]),
                 inv_mix(t_d[63:32]), inv_mix(t_d[31:0])};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            rnd_q       <= '0;
            pt_q        <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        st_q       <= ciphertext ^ key;
                        rk_q       <= key;
                        rnd_q      <= 4'd9;
                        in_ready_q <= 1'b0;
                        fsm_q      <= ROUND;
                    end
                end
                ROUND: begin
                    rk_q <= rk_d;
                    if (rnd_q != 4'd0) begin
                        st_q  <= mix_d;
                        rnd_q <= rnd_q - 4'd1;
                    end else begin
                        pt_q        <= t_d;
                        key_q       <= rk_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign plaintext = pt_q;
    assign out_key   = key_q;

endmodule
